// File: rtl/alu_stage.sv
// Execute stage: single-cycle ADD/SUB/logic/SLT/shifts, plus an iterative shift-add MUL
// that stalls upstream while busy. The registered result doubles as decode's bypass source.
module alu_stage #(
  parameter int REG_ADDRESS_SIZE = 5,
  parameter int REG_SIZE         = 32,
  parameter int ADDRESS_SIZE     = 32
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [REG_SIZE-1:0]                      ALU_operand1,
  input  logic [REG_SIZE-1:0]                      ALU_operand2,
  input  logic [3:0]                               ALU_op,
  input  logic                                     ALU_valid_in,
  input  logic [REG_ADDRESS_SIZE+3+ADDRESS_SIZE-1:0] ALU_static_in,
  input  logic                                     ALU_stall_in,
  output logic [REG_SIZE-1:0]                      ALU_result,
  output logic                                     ALU_valid_out,
  output logic [REG_ADDRESS_SIZE+3+ADDRESS_SIZE-1:0] ALU_static_out,
  output logic [REG_ADDRESS_SIZE:0]                ALU_d,
  output logic [REG_SIZE-1:0]                      ALU_bypass,
  output logic                                     ALU_stall
);

  localparam int STATIC_W = REG_ADDRESS_SIZE + 3 + ADDRESS_SIZE;
  localparam int SHW      = $clog2(REG_SIZE);
  localparam int CNTW     = $clog2(REG_SIZE);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  state_t                state_q, state_d;
  logic [CNTW-1:0]       counter;
  logic [REG_SIZE-1:0]   mcand, mplier, acc;
  logic [STATIC_W-1:0]   mul_static;
  logic [REG_SIZE-1:0]   op_result;
  logic [REG_SIZE-1:0]   step_acc;
  logic                  last_step;
  logic                  accept_mul;
  logic                  slt;

  assign slt       = $signed(ALU_operand1) < $signed(ALU_operand2);
  assign step_acc  = mplier[0] ? acc + mcand : acc;
  assign last_step = (counter == CNTW'(REG_SIZE - 1));

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    op_result = '0;
    case (ALU_op)
      OP_ADD:  op_result = ALU_operand1 + ALU_operand2;
      OP_SUB:  op_result = ALU_operand1 - ALU_operand2;
      OP_AND:  op_result = ALU_operand1 & ALU_operand2;
      OP_OR:   op_result = ALU_operand1 | ALU_operand2;
      OP_XOR:  op_result = ALU_operand1 ^ ALU_operand2;
      OP_SLT:  op_result = {{(REG_SIZE-1){1'b0}}, slt};
      OP_SLL:  op_result = ALU_operand1 << ALU_operand2[SHW-1:0];
      OP_SRL:  op_result = ALU_operand1 >> ALU_operand2[SHW-1:0];
      default: op_result = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    accept_mul = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!ALU_stall_in && ALU_valid_in && ALU_op == OP_MUL) begin
          state_d    = ST_MUL;
          accept_mul = 1'b1;
        end
      end
      ST_MUL: begin
        if (last_step && !ALU_stall_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter        <= '0;
      mcand          <= '0;
      mplier         <= '0;
      acc            <= '0;
      mul_static     <= '0;
      ALU_result     <= '0;
      ALU_valid_out  <= 1'b0;
      ALU_static_out <= '0;
    end else begin
      if (accept_mul) begin
        mcand      <= ALU_operand1;
        mplier     <= ALU_operand2;
        acc        <= '0;
        counter    <= '0;
        mul_static <= ALU_static_in;
      end else if (state_q == ST_MUL) begin
        // Once the multiplier is fully shifted out, further steps add nothing, so a held final step is idempotent.
        acc    <= step_acc;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        if (!last_step) counter <= counter + CNTW'(1);
      end

      if (!ALU_stall_in) begin
        if (state_q == ST_IDLE && !accept_mul) begin
          ALU_result     <= op_result;
          ALU_valid_out  <= ALU_valid_in;
          ALU_static_out <= ALU_static_in;
        end else if (state_q == ST_MUL && last_step) begin
          ALU_result     <= step_acc;
          ALU_valid_out  <= 1'b1;
          ALU_static_out <= mul_static;
        end else begin
          ALU_result     <= '0;
          ALU_valid_out  <= 1'b0;
          ALU_static_out <= '0;
        end
      end
    end
  end

  assign ALU_stall  = (state_q == ST_MUL) | ALU_stall_in;
  assign ALU_bypass = ALU_result;
  assign ALU_d      = {ALU_static_out[STATIC_W-1 -: REG_ADDRESS_SIZE],
                       ALU_valid_out & ALU_static_out[ADDRESS_SIZE]};

endmodule

// File: doc/alu_stage.md
Name: alu_stage

Overview:
- Execute stage sitting directly downstream of the decode stage; consumes decoded operands, opcode and the static bundle, and produces a registered result for the memory stage.
- Single-cycle ops for add, sub, logic, compare and shifts; iterative shift-add MUL taking REG_SIZE cycles, with an upstream stall while busy.
- Registered result and destination tag are exported as the ALU bypass pair consumed by decode.

Parameters:
- REG_ADDRESS_SIZE, 5, register address width
- REG_SIZE, 32, datapath width
- ADDRESS_SIZE, 32, PC width carried in static bundle

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ALU_operand1  in  REG_SIZE  operand A from decode
- ALU_operand2  in  REG_SIZE  operand B / immediate from decode
- ALU_op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLL, 7 SRL, 8 MUL, 9-15 reserved
- ALU_valid_in  in  1  decode presents a real instruction
- ALU_static_in  in  REG_ADDRESS_SIZE+3+ADDRESS_SIZE  static bundle: [ADDRESS_SIZE-1:0] pc, [ADDRESS_SIZE] we, [ADDRESS_SIZE+1] mem_read, [ADDRESS_SIZE+2] mem_write, top REG_ADDRESS_SIZE bits rd
- ALU_stall_in  in  1  downstream (memory stage) stall
- ALU_result  out  REG_SIZE  registered result
- ALU_valid_out  out  1  registered valid
- ALU_static_out  out  REG_ADDRESS_SIZE+3+ADDRESS_SIZE  registered static bundle
- ALU_d  out  REG_ADDRESS_SIZE+1  bypass tag {rd, valid_out & we}
- ALU_bypass  out  REG_SIZE  equals ALU_result
- ALU_stall  out  1  freeze upstream stages

Behaviour:
- Reset (async, immediate): state=IDLE, counter=0, and all registered outputs (result, valid, static, multiplier registers) = 0. ALU_d=0, ALU_stall=ALU_stall_in.
- Outputs: ALU_stall = (state==MUL) | ALU_stall_in, purely combinational. ALU_d and ALU_bypass are derived from the output register only.
- Pipe register hold: when ALU_stall_in=1, the pipe register (result, valid, static) holds in every state.
- IDLE, ALU_stall_in=0, op != MUL or valid_in=0:
  - Next edge loads result, valid=valid_in and static_in. Latency is 1 cycle.
- IDLE, ALU_stall_in=0, valid_in=1, op==MUL:
  - Latch multiplicand, multiplier and static_in.
  - Clear accumulator; counter=0; state goes to MUL.
  - Pipe register loads a bubble (valid=0).
  - ALU_stall is not asserted in the accept cycle, so upstream advances and the MUL is never re-presented.
- State MUL, per cycle:
  - If accumulator bit 0 of the multiplier is set, add the shifted multiplicand.
  - Shift the multiplicand left and the multiplier right; counter++.
  - Inputs are ignored. Pipe register loads a bubble unless ALU_stall_in=1.
- State MUL, final step (counter==REG_SIZE-1):
  - If ALU_stall_in=0: load the low REG_SIZE bits of the product with valid=1 and the latched static, then go to IDLE.
  - If ALU_stall_in=1: complete the final accumulate, saturate the counter and stay in MUL until ALU_stall_in=0, then write and go to IDLE.
- MUL timing: result visible REG_SIZE+1 cycles after acceptance; ALU_stall high for exactly REG_SIZE cycles when not stalled downstream.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^REG_SIZE.
  - SLT is a signed compare; result 1 or 0, zero-extended.
  - SLL/SRL are logical shifts by operand2[$clog2(REG_SIZE)-1:0].
  - Reserved opcodes give result 0 but still pass valid and static.
- Bypass tag: ALU_d[0] = valid_out & static_out we bit. Bubbles and non-writing instructions never create a dependency.
- Reset mid-MUL: aborts the multiply, returns to IDLE, and the result is lost. No output glitches beyond the async clear.

Test Plan:
- ADD: op1=5, op2=0xFFFFFFFF, rd=3, we=1 -> next cycle result=4, ALU_d={3,1}, ALU_bypass=4, ALU_stall=0.
- SLT/SRL: SLT 0xFFFFFFFE vs 1 -> result 1. SRL 0x80000000 by 31 -> result 1. SLL 1 by 0x25 -> result 0x20, since only the low 5 bits are used.
- MUL: 0x0001_0003 x 0x0000_0005, then ADD issued right after -> ALU_stall high for 32 cycles and valid_out=0 during them. Result 0x0005_000F appears 33 cycles after issue. The following ADD result appears the next cycle, unchanged.
- Downstream stall: ALU_stall_in high for 3 cycles mid-stream -> result, valid and static frozen, ALU_stall=1. The instruction held at input executes exactly once after release.
- MUL with stall_in asserted on the final step -> stays in MUL; product written the cycle after stall_in drops. Product is 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001.
- Reset asserted at MUL cycle 10 -> outputs 0 immediately. After release, state is IDLE and a new ADD completes in 1 cycle.
